// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for a 5-stage RV32 pipeline: forwarding, load-use/RAW stalls, memory wait/timeout, perf counters.
// Latency: stall/flush/forward combinational; FSM, mem_err and counters registered (1 cycle).
// Backpressure: a not-ready data memory freezes every stage until ready or timeout abort.
module hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int FWD_EN      = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_d_i,
  input  logic [REG_ADDR_W-1:0] rs2_d_i,
  input  logic [REG_ADDR_W-1:0] rs1_e_i,
  input  logic [REG_ADDR_W-1:0] rs2_e_i,
  input  logic [REG_ADDR_W-1:0] rd_e_i,
  input  logic [REG_ADDR_W-1:0] rd_m_i,
  input  logic [REG_ADDR_W-1:0] rd_w_i,
  input  logic                  reg_write_e_i,
  input  logic                  reg_write_m_i,
  input  logic                  reg_write_w_i,
  input  logic                  result_src_e_i,
  input  logic                  pc_src_e_i,
  input  logic                  mem_req_m_i,
  input  logic                  mem_ready_m_i,
  input  logic                  cnt_clr_i,
  output logic                  stall_f_o,
  output logic                  stall_d_o,
  output logic                  stall_e_o,
  output logic                  stall_m_o,
  output logic                  stall_w_o,
  output logic                  flush_d_o,
  output logic                  flush_e_o,
  output logic                  flush_w_o,
  output logic [1:0]            forward_ae_o,
  output logic [1:0]            forward_be_o,
  output logic                  mem_err_o,
  output logic [CNT_W-1:0]      cnt_cycles_o,
  output logic [CNT_W-1:0]      cnt_stalls_o,
  output logic [CNT_W-1:0]      cnt_flushes_o
);

  localparam int WC_W = (MEM_TIMEOUT < 2) ? 2 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_ERR} state_e;

  state_e            state_q, state_d;
  logic [WC_W-1:0]   wait_q, wait_d;
  logic              mem_err_q;
  logic [CNT_W-1:0]  cyc_q, stl_q, fls_q;

  logic       lw_stall, raw_stall, d_stall, timeout_hit, mem_stall;
  logic       stall_fd, flush_d, flush_e;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic hit(input logic [REG_ADDR_W-1:0] x,
                               input logic [REG_ADDR_W-1:0] rd,
                               input logic                  we);
    return we && (rd != '0) && (rd == x);
  endfunction

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD_EN != 0) begin
      if (hit(rs1_e_i, rd_m_i, reg_write_m_i))      fwd_a = 2'b10;
      else if (hit(rs1_e_i, rd_w_i, reg_write_w_i)) fwd_a = 2'b01;
      if (hit(rs2_e_i, rd_m_i, reg_write_m_i))      fwd_b = 2'b10;
      else if (hit(rs2_e_i, rd_w_i, reg_write_w_i)) fwd_b = 2'b01;
    end
  end

  assign lw_stall  = (FWD_EN != 0) && result_src_e_i && (rd_e_i != '0) &&
                     ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));
  // W is not checked: the regfile writes in the first half-cycle.
  assign raw_stall = (FWD_EN == 0) &&
                     (hit(rs1_d_i, rd_e_i, reg_write_e_i) || hit(rs2_d_i, rd_e_i, reg_write_e_i) ||
                      hit(rs1_d_i, rd_m_i, reg_write_m_i) || hit(rs2_d_i, rd_m_i, reg_write_m_i));
  assign d_stall   = lw_stall || raw_stall;

  // The cycle that reaches the timeout releases the pipeline instead of stalling again.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (state_q == MEM_WAIT) &&
                       (wait_q == WC_W'(MEM_TIMEOUT)) && !mem_ready_m_i;
  assign mem_stall   = mem_req_m_i && !mem_ready_m_i && (state_q != MEM_ERR) && !timeout_hit;

  assign stall_fd = mem_stall || d_stall;
  assign flush_d  = !mem_stall && pc_src_e_i;
  assign flush_e  = !mem_stall && (d_stall || pc_src_e_i);

  assign stall_f_o     = !rst && stall_fd;
  assign stall_d_o     = !rst && stall_fd;
  assign stall_e_o     = !rst && mem_stall;
  assign stall_m_o     = !rst && mem_stall;
  assign stall_w_o     = !rst && mem_stall;
  assign flush_d_o     = !rst && flush_d;
  assign flush_e_o     = !rst && flush_e;
  assign flush_w_o     = !rst && (state_q == MEM_ERR);
  assign forward_ae_o  = rst ? 2'b00 : fwd_a;
  assign forward_be_o  = rst ? 2'b00 : fwd_b;
  assign mem_err_o     = mem_err_q;
  assign cnt_cycles_o  = cyc_q;
  assign cnt_stalls_o  = stl_q;
  assign cnt_flushes_o = fls_q;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      RUN: begin
        if (mem_req_m_i && !mem_ready_m_i) begin
          state_d = MEM_WAIT;
          wait_d  = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready_m_i) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (timeout_hit) begin
          state_d = MEM_ERR;
          wait_d  = '0;
        end else if (wait_q != '1) begin
          wait_d  = wait_q + WC_W'(1);
        end
      end
      MEM_ERR: state_d = RUN;
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= (state_d == MEM_ERR);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
      stl_q <= '0;
      fls_q <= '0;
    end else if (cnt_clr_i) begin
      cyc_q <= '0;
      stl_q <= '0;
      fls_q <= '0;
    end else begin
      if (cyc_q != '1)              cyc_q <= cyc_q + CNT_W'(1);
      if (stall_fd && stl_q != '1)  stl_q <= stl_q + CNT_W'(1);
      if (flush_d && fls_q != '1)   fls_q <= fls_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: instance A (forwarding, timeout 4, 32-bit counters), instance B (no forwarding,
// no timeout, 4-bit counters) share stimulus; directed cases then random traffic against a reference model.
module tb_hazard_ctrl;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [RW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic we_e, we_m, we_w, ld_e, pc_e, req_m, rdy_m, clr;

  logic sf_a, sd_a, se_a, sm_a, sw_a, fd_a, fe_a, fw_a, me_a;
  logic sf_b, sd_b, se_b, sm_b, sw_b, fd_b, fe_b, fw_b, me_b;
  logic [1:0] fa_a, fb_a, fa_b, fb_b;
  logic [31:0] cc_a, cs_a, cf_a;
  logic [3:0]  cc_b, cs_b, cf_b;
  logic [12:0] obs_a, obs_b;

  assign obs_a = {sf_a, sd_a, se_a, sm_a, sw_a, fd_a, fe_a, fw_a, fa_a, fb_a, me_a};
  assign obs_b = {sf_b, sd_b, se_b, sm_b, sw_b, fd_b, fe_b, fw_b, fa_b, fb_b, me_b};

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_W(RW), .FWD_EN(1), .MEM_TIMEOUT(4), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .rs1_d_i(rs1_d), .rs2_d_i(rs2_d), .rs1_e_i(rs1_e), .rs2_e_i(rs2_e),
    .rd_e_i(rd_e), .rd_m_i(rd_m), .rd_w_i(rd_w), .reg_write_e_i(we_e), .reg_write_m_i(we_m),
    .reg_write_w_i(we_w), .result_src_e_i(ld_e), .pc_src_e_i(pc_e), .mem_req_m_i(req_m),
    .mem_ready_m_i(rdy_m), .cnt_clr_i(clr), .stall_f_o(sf_a), .stall_d_o(sd_a), .stall_e_o(se_a),
    .stall_m_o(sm_a), .stall_w_o(sw_a), .flush_d_o(fd_a), .flush_e_o(fe_a), .flush_w_o(fw_a),
    .forward_ae_o(fa_a), .forward_be_o(fb_a), .mem_err_o(me_a),
    .cnt_cycles_o(cc_a), .cnt_stalls_o(cs_a), .cnt_flushes_o(cf_a));

  hazard_ctrl #(.REG_ADDR_W(RW), .FWD_EN(0), .MEM_TIMEOUT(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .rs1_d_i(rs1_d), .rs2_d_i(rs2_d), .rs1_e_i(rs1_e), .rs2_e_i(rs2_e),
    .rd_e_i(rd_e), .rd_m_i(rd_m), .rd_w_i(rd_w), .reg_write_e_i(we_e), .reg_write_m_i(we_m),
    .reg_write_w_i(we_w), .result_src_e_i(ld_e), .pc_src_e_i(pc_e), .mem_req_m_i(req_m),
    .mem_ready_m_i(rdy_m), .cnt_clr_i(clr), .stall_f_o(sf_b), .stall_d_o(sd_b), .stall_e_o(se_b),
    .stall_m_o(sm_b), .stall_w_o(sw_b), .flush_d_o(fd_b), .flush_e_o(fe_b), .flush_w_o(fw_b),
    .forward_ae_o(fa_b), .forward_be_o(fb_b), .mem_err_o(me_b),
    .cnt_cycles_o(cc_b), .cnt_stalls_o(cs_b), .cnt_flushes_o(cf_b));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: index 0 = instance A, 1 = instance B.
  bit     m_wait[2];
  int     m_wlen[2];
  bit     m_err[2];
  longint m_cc[2], m_cs[2], m_cf[2];

  function automatic int tmo(input int k);
    return (k == 0) ? 4 : 0;
  endfunction

  function automatic longint cmax(input int k);
    return (k == 0) ? 64'hFFFF_FFFF : 64'd15;
  endfunction

  function automatic bit hitf(input logic [RW-1:0] x, input logic [RW-1:0] rd, input logic we);
    return we && (rd != 0) && (rd == x);
  endfunction

  function automatic bit timeout_now(input int k);
    return (tmo(k) != 0) && m_wait[k] && (m_wlen[k] == tmo(k)) && !rdy_m;
  endfunction

  function automatic logic [12:0] model_ctl(input int k);
    bit fwd, ds, ms, sf, fd, fe;
    logic [1:0] fa, fb;
    fwd = (k == 0);
    fa = 0;
    fb = 0;
    if (fwd) begin
      fa = hitf(rs1_e, rd_m, we_m) ? 2'd2 : (hitf(rs1_e, rd_w, we_w) ? 2'd1 : 2'd0);
      fb = hitf(rs2_e, rd_m, we_m) ? 2'd2 : (hitf(rs2_e, rd_w, we_w) ? 2'd1 : 2'd0);
      ds = ld_e && (rd_e != 0) && (rd_e == rs1_d || rd_e == rs2_d);
    end else begin
      ds = hitf(rs1_d, rd_e, we_e) || hitf(rs2_d, rd_e, we_e) ||
           hitf(rs1_d, rd_m, we_m) || hitf(rs2_d, rd_m, we_m);
    end
    ms = req_m && !rdy_m && !m_err[k] && !timeout_now(k);
    sf = ms || ds;
    fd = !ms && pc_e;
    fe = !ms && (ds || pc_e);
    return {sf, sf, ms, ms, ms, fd, fe, m_err[k], fa, fb, m_err[k]};
  endfunction

  function automatic longint sat_inc(input longint v, input bit inc, input int k);
    return (inc && v < cmax(k)) ? v + 1 : v;
  endfunction

  task automatic model_advance(input int k, input bit sf, input bit fd);
    bit to;
    to = timeout_now(k);
    if (m_err[k]) begin
      m_err[k] = 0;
    end else if (!m_wait[k]) begin
      if (req_m && !rdy_m) begin
        m_wait[k] = 1;
        m_wlen[k] = 1;
      end
    end else if (rdy_m) begin
      m_wait[k] = 0;
    end else if (to) begin
      m_wait[k] = 0;
      m_err[k]  = 1;
    end else begin
      m_wlen[k]++;
    end
    if (clr) begin
      m_cc[k] = 0; m_cs[k] = 0; m_cf[k] = 0;
    end else begin
      m_cc[k] = sat_inc(m_cc[k], 1'b1, k);
      m_cs[k] = sat_inc(m_cs[k], sf, k);
      m_cf[k] = sat_inc(m_cf[k], fd, k);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_wait[k] = 0; m_wlen[k] = 0; m_err[k] = 0;
      m_cc[k] = 0; m_cs[k] = 0; m_cf[k] = 0;
    end
  endtask

  task automatic idle();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    we_e = 0; we_m = 0; we_w = 0; ld_e = 0; pc_e = 0; req_m = 0; rdy_m = 0; clr = 0;
  endtask

  // Entered at posedge+1 with inputs applied; checks, then steps the model over the next edge.
  task automatic run_cycle();
    logic [12:0] ea, eb;
    #3;
    ea = model_ctl(0);
    eb = model_ctl(1);
    check("ctl_a", obs_a, ea);
    check("ctl_b", obs_b, eb);
    check("cycles_a", cc_a, m_cc[0]);
    check("stalls_a", cs_a, m_cs[0]);
    check("flushes_a", cf_a, m_cf[0]);
    check("cycles_b", cc_b, m_cc[1]);
    check("stalls_b", cs_b, m_cs[1]);
    check("flushes_b", cf_b, m_cf[1]);
    model_advance(0, ea[12], ea[7]);
    model_advance(1, eb[12], eb[7]);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl_a"}, obs_a, 0);
    check({tag, "_ctl_b"}, obs_b, 0);
    check({tag, "_cnt_a"}, {cc_a, cs_a}, 0);
    check({tag, "_cnt_b"}, {cc_b, cs_b, cf_b, cf_a}, 0);
  endtask

  logic [31:0] s0;

  initial begin
    idle();
    model_reset();
    // Reset holds outputs low even with inputs that would stall and flush.
    req_m = 1; pc_e = 1; ld_e = 1; rd_e = 7; rs1_d = 7; rd_m = 3; we_m = 1; rs1_e = 3;
    #1 rst = 1;
    #1 check_all_zero("reset");
    @(posedge clk);
    #1 rst = 0;
    idle();

    // Forwarding: M over W, then W, none for an unrelated source.
    rd_m = 5; we_m = 1; rd_w = 5; we_w = 1; rs1_e = 5; rs2_e = 6;
    #1 check("t1_fwd_m", fa_a, 2'b10);
    check("t1_fwd_be_none", fb_a, 2'b00);
    run_cycle();
    rd_m = 0;
    #1 check("t1_fwd_w", fa_a, 2'b01);
    run_cycle();

    idle();
    ld_e = 1; rd_e = 7; rs2_d = 7;
    #1 check("t2_lw_stall", {sf_a, sd_a, fe_a, se_a}, 4'b1110);
    run_cycle();

    idle();
    pc_e = 1;
    #1 check("t3_branch", {fd_a, fe_a, sf_a, sd_a}, 4'b1100);
    run_cycle();

    // Memory wait with a deferred branch.
    idle();
    s0 = cs_a;
    req_m = 1; pc_e = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check("t4_wait", {sf_a, sd_a, se_a, sm_a, sw_a, fd_a, fe_a, fw_a}, 8'b11111000);
      run_cycle();
    end
    rdy_m = 1;
    #1 check("t4_release", {sf_a, fd_a, fe_a}, 3'b011);
    run_cycle();
    check("t4_cnt_stalls", cs_a - s0, 3);
    idle();
    run_cycle();

    // Timeout on A: 4 stalled cycles, release cycle, then the abort cycle, then a fresh wait.
    req_m = 1;
    for (int i = 0; i < 4; i++) begin
      #1 check("t5_wait_stall", sf_a, 1'b1);
      run_cycle();
    end
    #1 check("t5_timeout_cycle", {sf_a, me_a, fw_a}, 3'b000);
    run_cycle();
    #1 check("t5_abort", {sf_a, se_a, me_a, fw_a}, 4'b0011);
    check("t5_b_still_waits", sf_b, 1'b1);
    run_cycle();
    #1 check("t5_fresh_wait", {sf_a, me_a, fw_a}, 3'b100);
    run_cycle();
    rdy_m = 1;
    run_cycle();

    // No-forwarding build stalls on RAW against M; forwarding build does not.
    idle();
    rd_m = 3; we_m = 1; rs1_d = 3; rs1_e = 3;
    #1 check("t6_raw_b", {sf_b, sd_b, fe_b, fa_b, fb_b}, 7'b1110000);
    check("t6_fwd_a", {sf_a, fa_a}, 3'b010);
    run_cycle();

    // Asynchronous reset in the middle of a memory wait.
    idle();
    req_m = 1;
    for (int i = 0; i < 3; i++) run_cycle();
    #2 rst = 1;
    #1 check_all_zero("t6_rst_mid_wait");
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    idle();
    run_cycle();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      rs1_d = RW'($urandom_range(0, 7)); rs2_d = RW'($urandom_range(0, 7));
      rs1_e = RW'($urandom_range(0, 7)); rs2_e = RW'($urandom_range(0, 7));
      rd_e  = RW'($urandom_range(0, 7)); rd_m  = RW'($urandom_range(0, 7));
      rd_w  = RW'($urandom_range(0, 7));
      we_e = 1'($urandom_range(0, 1)); we_m = 1'($urandom_range(0, 1)); we_w = 1'($urandom_range(0, 1));
      ld_e = ($urandom_range(0, 3) == 0);
      pc_e = ($urandom_range(0, 5) == 0);
      clr  = ($urandom_range(0, 40) == 0);
      if (!req_m)     req_m = ($urandom_range(0, 3) == 0);
      else if (rdy_m) req_m = 1'($urandom_range(0, 1));
      rdy_m = req_m ? ($urandom_range(0, 5) == 0) : 1'($urandom_range(0, 1));
      run_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
